vedic_mult_seq_ctrl: RTL and testbench

Sequencing controller that time-shares one external combinational HALF x HALF Vedic multiplier core to compute a full WIDTH x WIDTH product.
- Splits each operand into halves and issues four partial products, one per cycle, to the shared core.
- Shifts and accumulates the partial products into a 2*WIDTH result.
- Sits between the operand source (start/ready handshake) and the shared multiplier core.
- Replaces four parallel sub-multipliers plus adder tree in area-constrained builds.

---
 rtl/vedic_mult_seq_ctrl_pkg.sv | 36 +++
 rtl/vedic_mult_seq_ctrl_if.sv | 36 +++
 rtl/vedic_mult_seq_ctrl_pp_shift_acc.sv | 49 ++++
 rtl/vedic_mult_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_vedic_mult_seq_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/vedic_mult_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vedic_pkg
// Shared definitions for the sequenced Vedic multiplier controller:
//   state_e      - controller state encoding (IDLE / CALC / DONE)
//   NUM_STEPS    - number of partial products per full product
//   SEL_A_HI     - per-step select: 1 = feed the high half of A to the core
//   SEL_B_HI     - per-step select: 1 = feed the high half of B to the core
//   step_shift() - per-step left shift applied to the core product
// ---------------------------------------------------------------------------
package vedic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned NUM_STEPS = 32'd4;

   // Step order: lo*lo, hi*lo, lo*hi, hi*hi (bit index = step number).
   localparam logic [NUM_STEPS-1:0] SEL_A_HI = 4'b1010;
   localparam logic [NUM_STEPS-1:0] SEL_B_HI = 4'b1100;

   // Shift table {0, HALF, HALF, 2*HALF} indexed by step.
   function automatic int unsigned step_shift(input logic [1:0] step, input int unsigned half);
      int unsigned sh;
      case (step)
         2'd0:       sh = 32'd0;
         2'd1, 2'd2: sh = half;
         2'd3:       sh = 32'd2 * half;
         default:    sh = 32'd0;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/vedic_mult_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// vedic_mult_seq_ctrl_if
// Bundles the operand handshake and the shared-core connection.
//   start/a/b        - operand request from the source
//   ready/busy/done  - controller status, done pulses when p updates
//   p                - 2*WIDTH product register
//   mul_a/mul_b      - HALF-bit operands to the shared multiplier core
//   mul_p            - combinational core product
// Modports: slave = the controller, master = source plus multiplier core.
// ---------------------------------------------------------------------------
interface vedic_mult_seq_ctrl_if #(
   parameter int WIDTH = 16
);
   localparam int HALF = WIDTH / 2;

   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 ready;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   p;
   logic [HALF-1:0]      mul_a;
   logic [HALF-1:0]      mul_b;
   logic [2*HALF-1:0]    mul_p;

   modport slave (
      input  start, a, b, mul_p,
      output ready, busy, done, p, mul_a, mul_b
   );

   modport master (
      output start, a, b, mul_p,
      input  ready, busy, done, p, mul_a, mul_b
   );
endinterface

// File: rtl/vedic_mult_seq_ctrl_pp_shift_acc.sv
// ---------------------------------------------------------------------------
// pp_shift_acc
// Shift-and-add accumulator for the partial products.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - zero the accumulator (new product accepted)
//   enable     - add the shifted partial product this cycle
//   step       - current partial-product index, selects the shift
//   mul_p      - partial product from the shared core (WIDTH bits)
//   acc        - 2*WIDTH running sum
// ---------------------------------------------------------------------------
module pp_shift_acc
   import vedic_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               enable,
   input  logic [1:0]         step,
   input  logic [WIDTH-1:0]   mul_p,
   output logic [2*WIDTH-1:0] acc
);
   localparam int unsigned HALF = WIDTH / 2;

   logic [2*WIDTH-1:0] term_s;
   logic [2*WIDTH-1:0] acc_r;

   // Zero-extend the partial product to full width, then apply the step shift.
   always_comb begin
      term_s = {{WIDTH{1'b0}}, mul_p} << step_shift(step, HALF);
   end

   // Accumulator register: clear has priority over accumulate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= '0;
      end else if (clear) begin
         acc_r <= '0;
      end else if (enable) begin
         acc_r <= acc_r + term_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   assign acc = acc_r;

endmodule

// File: rtl/vedic_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// vedic_mult_seq_ctrl
// Computes a WIDTH x WIDTH unsigned product by issuing four HALF x HALF
// partial products, one per cycle, to a shared external multiplier core.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of vedic_mult_seq_ctrl_if:
//           start/a/b in, ready/busy/done/p out,
//           mul_a/mul_b to the core, mul_p back from the core
// A start accepted at edge N yields done during the cycle after edge N+4;
// the controller returns to IDLE one cycle later.
// ---------------------------------------------------------------------------
module vedic_mult_seq_ctrl
   import vedic_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   vedic_mult_seq_ctrl_if.slave  bus
);
   localparam int HALF = WIDTH / 2;

   state_e               state_r;
   state_e               state_s;
   logic [1:0]           step_r;
   logic [1:0]           step_s;
   logic [WIDTH-1:0]     a_r;
   logic [WIDTH-1:0]     a_s;
   logic [WIDTH-1:0]     b_r;
   logic [WIDTH-1:0]     b_s;
   logic [2*WIDTH-1:0]   p_r;
   logic                 ready_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 clear_s;
   logic                 enable_s;
   logic                 p_load_s;
   logic [HALF-1:0]      mul_a_s;
   logic [HALF-1:0]      mul_b_s;
   logic [2*WIDTH-1:0]   acc_s;
   logic [2*WIDTH-1:0]   p_next_s;

   pp_shift_acc #(
      .WIDTH (WIDTH)
   ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear_s),
      .enable (enable_s),
      .step   (step_r),
      .mul_p  (bus.mul_p),
      .acc    (acc_s)
   );

   // Next-state, step sequencing and operand capture.
   always_comb begin
      state_s  = state_r;
      step_s   = step_r;
      a_s      = a_r;
      b_s      = b_r;
      clear_s  = 1'b0;
      enable_s = 1'b0;
      p_load_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = ST_CALC;
               step_s  = 2'd0;
               a_s     = bus.a;
               b_s     = bus.b;
               clear_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            enable_s = 1'b1;
            if (step_r == 2'd3) begin
               // Step counter parks at 3; it restarts only from IDLE.
               state_s  = ST_DONE;
               p_load_s = 1'b1;
            end else begin
               step_s = step_r + 2'd1;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            step_s  = 2'd0;
         end
      endcase
   end

   // Core operand decode: half-select per step, zero outside CALC.
   always_comb begin
      mul_a_s = '0;
      mul_b_s = '0;
      if (state_r == ST_CALC) begin
         mul_a_s = SEL_A_HI[step_r] ? a_r[WIDTH-1:HALF] : a_r[HALF-1:0];
         mul_b_s = SEL_B_HI[step_r] ? b_r[WIDTH-1:HALF] : b_r[HALF-1:0];
      end else begin
         mul_a_s = '0;
         mul_b_s = '0;
      end
   end

   // Last partial product is folded in directly so p is ready on the DONE edge.
   always_comb begin
      p_next_s = acc_s + ({{WIDTH{1'b0}}, bus.mul_p} << WIDTH);
   end

   // State, operand and result registers plus registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         step_r  <= 2'd0;
         a_r     <= '0;
         b_r     <= '0;
         p_r     <= '0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         step_r  <= step_s;
         a_r     <= a_s;
         b_r     <= b_s;
         if (p_load_s) begin
            p_r <= p_next_s;
         end else begin
            p_r <= p_r;
         end
         ready_r <= (state_s == ST_IDLE);
         busy_r  <= (state_s == ST_CALC);
         done_r  <= (state_s == ST_DONE);
      end
   end

   assign bus.ready = ready_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.p     = p_r;
   assign bus.mul_a = mul_a_s;
   assign bus.mul_b = mul_b_s;

endmodule

// File: tb/tb_vedic_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vedic_mult_seq_ctrl
// Directed vectors; expected products are queued at issue time and a
// negedge monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_vedic_mult_seq_ctrl;
   localparam int WIDTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   vedic_mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

   vedic_mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Shared multiplier core model.
   assign bus.mul_p = 16'(bus.mul_a) * 16'(bus.mul_b);

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int done_cnt = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest queued product.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_done: got done with p=0x%0h expected no pending product", bus.p);
         end else begin
            check("product", bus.p, exp_q.pop_front());
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (bus.ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_wait", 32'(bus.ready), 32'd1);
   endtask

   task automatic issue(input logic [15:0] av, input logic [15:0] bv);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic do_mult(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] exp);
      int cyc = 0;
      wait_ready();
      exp_q.push_back(exp);
      issue(av, bv);
      while (bus.done !== 1'b1 && cyc < 12) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", cyc, 32'd4);
   endtask

   initial begin : stim
      logic [7:0] t1_a [4] = '{8'h34, 8'h12, 8'h34, 8'h12};
      logic [7:0] t1_b [4] = '{8'h78, 8'h78, 8'h56, 8'h56};
      int d0;
      int dk[$];
      logic stable;

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_busy",  32'(bus.busy),  32'd0);
      check("rst_done",  32'(bus.done),  32'd0);
      check("rst_p",     bus.p,          32'd0);
      check("rst_mul_a", 32'(bus.mul_a), 32'd0);
      check("rst_mul_b", 32'(bus.mul_b), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Test 1: 0x1234 * 0x5678 with per-step operand checks
      exp_q.push_back(32'h0626_0060);
      issue(16'h1234, 16'h5678);
      check("t1_busy", 32'(bus.busy), 32'd1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t1_mul_a_s%0d", k), 32'(bus.mul_a), 32'(t1_a[k]));
         check($sformatf("t1_mul_b_s%0d", k), 32'(bus.mul_b), 32'(t1_b[k]));
         @(posedge clk); #1;
      end
      check("t1_done_latency", 32'(bus.done), 32'd1);
      check("t1_ready_in_done", 32'(bus.ready), 32'd0);
      check("t1_mul_a_idle", 32'(bus.mul_a), 32'd0);

      // Test 2: max operands, then zero operand
      do_mult(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
      do_mult(16'h0000, 16'hABCD, 32'h0000_0000);

      // Test 3: start hammered during CALC/DONE with changing operands
      wait_ready();
      d0 = done_cnt;
      exp_q.push_back(32'h0000_0242);
      issue(16'h0011, 16'h0022);
      for (int i = 0; i < 5; i++) begin
         bus.start = 1'b1;
         bus.a     = 16'hF0F0 ^ 16'(i * 257);
         bus.b     = 16'h0F0F + 16'(i);
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("t3_one_done", done_cnt - d0, 32'd1);
      check("t3_p", bus.p, 32'h0000_0242);
      check("t3_idle", 32'(bus.ready), 32'd1);

      // Test 4: reset during step2 of 0x00FF * 0x0100
      wait_ready();
      issue(16'h00FF, 16'h0100);
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("t4_step2_mul_a", 32'(bus.mul_a), 32'h0000_00FF);
      check("t4_step2_mul_b", 32'(bus.mul_b), 32'h0000_0001);
      rst_n = 1'b0;
      #1;
      check("t4_rst_ready", 32'(bus.ready), 32'd1);
      check("t4_rst_done",  32'(bus.done),  32'd0);
      check("t4_rst_busy",  32'(bus.busy),  32'd0);
      check("t4_rst_p",     bus.p,          32'd0);
      check("t4_rst_mul_a", 32'(bus.mul_a), 32'd0);
      #2;
      rst_n = 1'b1;
      do_mult(16'h0003, 16'h0005, 32'h0000_000F);

      // Test 5: start held high, back-to-back products
      wait_ready();
      d0 = done_cnt;
      repeat (3) exp_q.push_back(32'h0001_0000);
      bus.a     = 16'h0100;
      bus.b     = 16'h0100;
      bus.start = 1'b1;
      @(posedge clk); #1;
      stable = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) dk.push_back(k);
         if (k >= 4 && bus.p !== 32'h0001_0000) stable = 1'b0;
      end
      bus.start = 1'b0;
      check("t5_done_count", dk.size(), 32'd3);
      check("t5_done_k0", (dk.size() > 0) ? dk[0] : -1, 32'd4);
      check("t5_done_k1", (dk.size() > 1) ? dk[1] : -1, 32'd10);
      check("t5_done_k2", (dk.size() > 2) ? dk[2] : -1, 32'd16);
      check("t5_p_stable", 32'(stable), 32'd1);

      repeat (4) @(posedge clk);
      #1;
      check("t5_monitor_dones", done_cnt - d0, 32'd3);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
